// File: rtl/hyperbus_rx_packer.sv
// Repacks HyperBus read words (16-bit, big-byte-first) into little-endian 32-bit
// uDMA words, dropping the odd-start pad byte and any bytes past the programmed length.
module hyperbus_rx_packer #(
    parameter int LEN_W = 16
) (
    input  logic             clk0,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [LEN_W-1:0] len_bytes_i,
    input  logic             odd_start_i,
    input  logic             in_valid_i,
    input  logic [15:0]      in_data_i,
    output logic             in_ready_o,
    output logic             out_valid_o,
    output logic [31:0]      out_data_o,
    output logic [2:0]       out_bytes_o,
    input  logic             ready_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             overflow_o
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_LAST} state_t;

    state_t           state_q, state_d;
    logic [23:0]      acc_q, acc_d;
    logic [1:0]       cnt_q, cnt_d;
    logic [LEN_W-1:0] rem_q, rem_d;
    logic             odd_q, odd_d;
    logic             tail_q, tail_d;
    logic [31:0]      out_data_q, out_data_d;
    logic [2:0]       out_bytes_q, out_bytes_d;
    logic             out_valid_q, out_valid_d;
    logic             done_q, done_d;
    logic             ovf_q, ovf_d;

    logic             in_ready;
    logic             out_free;
    logic [1:0]       n_raw;
    logic [1:0]       take_n;
    logic [15:0]      new_raw;
    logic [15:0]      new_bytes;
    logic [39:0]      comb_bytes;
    logic [2:0]       total;
    logic [LEN_W-1:0] rem_after;

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        rem_d       = rem_q;
        odd_d       = odd_q;
        tail_d      = tail_q;
        out_data_d  = out_data_q;
        out_bytes_d = out_bytes_q;
        out_valid_d = out_valid_q;
        done_d      = 1'b0;
        ovf_d       = ovf_q;
        in_ready    = 1'b0;

        out_free = !out_valid_q || ready_i;

        // Incoming bytes, earliest in the low byte; the pad byte is skipped on an odd start.
        n_raw     = odd_q ? 2'd1 : 2'd2;
        new_raw   = odd_q ? {8'h00, in_data_i[7:0]} : {in_data_i[7:0], in_data_i[15:8]};
        take_n    = (rem_q < LEN_W'(n_raw)) ? 2'd1 : n_raw;
        new_bytes = (take_n == 2'd1) ? {8'h00, new_raw[7:0]} : new_raw;
        comb_bytes = {16'h0000, acc_q} | ({24'h000000, new_bytes} << {cnt_q, 3'b000});
        total      = {1'b0, cnt_q} + {1'b0, take_n};
        rem_after  = rem_q - LEN_W'(take_n);

        if (out_valid_q && ready_i) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid_i) begin
                    ovf_d = 1'b1;
                end
                if (start_i) begin
                    ovf_d = 1'b0;
                    if (len_bytes_i != '0) begin
                        rem_d   = len_bytes_i;
                        odd_d   = odd_start_i;
                        acc_d   = '0;
                        cnt_d   = '0;
                        tail_d  = 1'b0;
                        state_d = S_RUN;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            S_RUN: begin
                in_ready = out_free && !tail_q;
                if (tail_q) begin
                    if (out_free) begin
                        out_data_d  = {24'h000000, acc_q[7:0]};
                        out_bytes_d = 3'd1;
                        out_valid_d = 1'b1;
                        acc_d       = '0;
                        cnt_d       = '0;
                        tail_d      = 1'b0;
                        state_d     = S_LAST;
                    end
                end else if (in_valid_i && out_free) begin
                    odd_d = 1'b0;
                    rem_d = rem_after;
                    if (total >= 3'd4) begin
                        out_data_d  = comb_bytes[31:0];
                        out_bytes_d = 3'd4;
                        out_valid_d = 1'b1;
                        acc_d       = {16'h0000, comb_bytes[39:32]};
                        cnt_d       = (total == 3'd5) ? 2'd1 : 2'd0;
                        // A fifth byte on the final beat goes out as its own word later.
                        if (rem_after == '0) begin
                            if (total == 3'd5) begin
                                tail_d = 1'b1;
                            end else begin
                                state_d = S_LAST;
                            end
                        end
                    end else if (rem_after == '0) begin
                        out_data_d  = comb_bytes[31:0];
                        out_bytes_d = total;
                        out_valid_d = 1'b1;
                        acc_d       = '0;
                        cnt_d       = '0;
                        state_d     = S_LAST;
                    end else begin
                        acc_d = comb_bytes[23:0];
                        cnt_d = total[1:0];
                    end
                end
            end
            S_LAST: begin
                if (out_valid_q && ready_i) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk0 or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            rem_q       <= '0;
            odd_q       <= 1'b0;
            tail_q      <= 1'b0;
            out_data_q  <= '0;
            out_bytes_q <= '0;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            odd_q       <= odd_d;
            tail_q      <= tail_d;
            out_data_q  <= out_data_d;
            out_bytes_q <= out_bytes_d;
            out_valid_q <= out_valid_d;
            done_q      <= done_d;
            ovf_q       <= ovf_d;
        end
    end

    assign in_ready_o  = in_ready;
    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign out_bytes_o = out_bytes_q;
    assign busy_o      = (state_q != S_IDLE);
    assign done_o      = done_q || ((state_q == S_LAST) && out_valid_q && ready_i);
    assign overflow_o  = ovf_q;

endmodule

// File: tb/tb_hyperbus_rx_packer.sv
// Directed bench for hyperbus_rx_packer: aligned, odd-start, trimmed, backpressured,
// zero-length/overflow and reset-abort transfers against hand-computed words.
module tb_hyperbus_rx_packer;

    logic        clk0 = 1'b0;
    logic        rst_i;
    logic        start_i;
    logic [15:0] len_bytes_i;
    logic        odd_start_i;
    logic        in_valid_i;
    logic [15:0] in_data_i;
    logic        in_ready_o;
    logic        out_valid_o;
    logic [31:0] out_data_o;
    logic [2:0]  out_bytes_o;
    logic        ready_i;
    logic        busy_o;
    logic        done_o;
    logic        overflow_o;

    int n_cmp = 0;
    int n_err = 0;

    logic [15:0] words     [0:7];
    logic [31:0] exp_data  [0:3];
    logic [2:0]  exp_bytes [0:3];

    hyperbus_rx_packer #(.LEN_W(16)) dut (
        .clk0        (clk0),
        .rst_i       (rst_i),
        .start_i     (start_i),
        .len_bytes_i (len_bytes_i),
        .odd_start_i (odd_start_i),
        .in_valid_i  (in_valid_i),
        .in_data_i   (in_data_i),
        .in_ready_o  (in_ready_o),
        .out_valid_o (out_valid_o),
        .out_data_o  (out_data_o),
        .out_bytes_o (out_bytes_o),
        .ready_i     (ready_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .overflow_o  (overflow_o)
    );

    always #5 clk0 = ~clk0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // Runs one transfer from words[]; stall_n cycles of ready_i=0 follow the first out_valid_o.
    task automatic run_xfer(input string tag, input logic [15:0] len, input logic odd,
                            input int nw, input int exp_n, input int exp_pops, input int stall_n);
        int  wi = 0;
        int  oi = 0;
        int  pops = 0;
        int  dones = 0;
        int  cyc = 0;
        int  stall_left = 0;
        bit  seen_first = 1'b0;
        bit  popped;
        @(posedge clk0); #1;
        start_i     = 1'b1;
        len_bytes_i = len;
        odd_start_i = odd;
        ready_i     = 1'b1;
        @(posedge clk0); #1;
        start_i    = 1'b0;
        in_valid_i = (nw > 0);
        in_data_i  = words[0];
        while (dones == 0 && cyc < 100) begin
            @(negedge clk0);
            if (cyc == 0) begin
                check_eq({tag, " ovf_clr"}, {31'b0, overflow_o}, 32'd0);
                check_eq({tag, " busy"}, {31'b0, busy_o}, 32'd1);
            end
            if (out_valid_o && !ready_i) begin
                check_eq({tag, " hold_data"}, out_data_o, exp_data[oi]);
                check_eq({tag, " hold_inrdy"}, {31'b0, in_ready_o}, 32'd0);
            end
            if (out_valid_o && ready_i) begin
                if (oi < exp_n) begin
                    check_eq({tag, " data"}, out_data_o, exp_data[oi]);
                    check_eq({tag, " bytes"}, {29'b0, out_bytes_o}, {29'b0, exp_bytes[oi]});
                    check_eq({tag, " done_at_acc"}, {31'b0, done_o}, (oi == exp_n - 1) ? 32'd1 : 32'd0);
                end
                oi++;
            end
            popped = in_valid_i && in_ready_o;
            if (popped) pops++;
            if (done_o) dones++;
            @(posedge clk0); #1;
            if (popped) wi++;
            in_valid_i = (wi < nw);
            in_data_i  = (wi < nw) ? words[wi] : 16'h0000;
            if (out_valid_o && !seen_first && stall_n > 0) begin
                seen_first = 1'b1;
                stall_left = stall_n;
            end
            if (stall_left > 0) begin
                ready_i = 1'b0;
                stall_left--;
            end else begin
                ready_i = 1'b1;
            end
            cyc++;
        end
        check_eq({tag, " done_cnt"}, dones, 1);
        check_eq({tag, " out_cnt"}, oi, exp_n);
        check_eq({tag, " pops"}, pops, exp_pops);
        @(negedge clk0);
        check_eq({tag, " idle_busy"}, {31'b0, busy_o}, 32'd0);
        check_eq({tag, " idle_ov"}, {31'b0, out_valid_o}, 32'd0);
    endtask

    initial begin
        rst_i       = 1'b1;
        start_i     = 1'b0;
        len_bytes_i = '0;
        odd_start_i = 1'b0;
        in_valid_i  = 1'b0;
        in_data_i   = '0;
        ready_i     = 1'b1;
        #3;
        check_eq("rst in_ready", {31'b0, in_ready_o}, 32'd1);
        check_eq("rst out_valid", {31'b0, out_valid_o}, 32'd0);
        check_eq("rst out_data", out_data_o, 32'd0);
        check_eq("rst out_bytes", {29'b0, out_bytes_o}, 32'd0);
        check_eq("rst busy", {31'b0, busy_o}, 32'd0);
        check_eq("rst done", {31'b0, done_o}, 32'd0);
        check_eq("rst overflow", {31'b0, overflow_o}, 32'd0);
        @(negedge clk0);
        @(negedge clk0);
        rst_i = 1'b0;

        // Zero-length start: done one cycle later, no output.
        @(posedge clk0); #1;
        start_i     = 1'b1;
        len_bytes_i = 16'd0;
        @(posedge clk0); #1;
        start_i = 1'b0;
        @(negedge clk0);
        check_eq("zero done", {31'b0, done_o}, 32'd1);
        check_eq("zero ov", {31'b0, out_valid_o}, 32'd0);
        check_eq("zero busy", {31'b0, busy_o}, 32'd0);
        @(negedge clk0);
        check_eq("zero done_clr", {31'b0, done_o}, 32'd0);

        // FIFO word while idle is popped and flagged.
        @(posedge clk0); #1;
        in_valid_i = 1'b1;
        in_data_i  = 16'h1234;
        @(negedge clk0);
        check_eq("ovf pop", {31'b0, in_ready_o}, 32'd1);
        @(posedge clk0); #1;
        in_valid_i = 1'b0;
        @(negedge clk0);
        check_eq("ovf set", {31'b0, overflow_o}, 32'd1);
        check_eq("ovf ov", {31'b0, out_valid_o}, 32'd0);

        // Even aligned; its start also clears overflow.
        words[0] = 16'h0011; words[1] = 16'h2233; words[2] = 16'h4455; words[3] = 16'h6677;
        exp_data[0] = 32'h33221100; exp_bytes[0] = 3'd4;
        exp_data[1] = 32'h77665544; exp_bytes[1] = 3'd4;
        run_xfer("even", 16'd8, 1'b0, 4, 2, 4, 0);

        // Odd start with 1-byte tail after a full word.
        words[0] = 16'hAA01; words[1] = 16'h0203; words[2] = 16'h0405;
        exp_data[0] = 32'h04030201; exp_bytes[0] = 3'd4;
        exp_data[1] = 32'h00000005; exp_bytes[1] = 3'd1;
        run_xfer("odd", 16'd5, 1'b1, 3, 2, 3, 0);

        // Trimmed final word.
        words[0] = 16'h1011; words[1] = 16'h1213;
        exp_data[0] = 32'h00121110; exp_bytes[0] = 3'd3;
        run_xfer("trim", 16'd3, 1'b0, 2, 1, 2, 0);

        // Backpressure on the first output word.
        words[0] = 16'h0011; words[1] = 16'h2233; words[2] = 16'h4455; words[3] = 16'h6677;
        exp_data[0] = 32'h33221100; exp_bytes[0] = 3'd4;
        exp_data[1] = 32'h77665544; exp_bytes[1] = 3'd4;
        run_xfer("bp", 16'd8, 1'b0, 4, 2, 4, 5);

        // Reset after the first word of a len=8 transfer.
        @(posedge clk0); #1;
        start_i     = 1'b1;
        len_bytes_i = 16'd8;
        odd_start_i = 1'b0;
        @(posedge clk0); #1;
        start_i    = 1'b0;
        in_valid_i = 1'b1;
        in_data_i  = 16'h0011;
        @(posedge clk0); #2;
        in_valid_i = 1'b0;
        rst_i      = 1'b1;
        #1;
        check_eq("arst in_ready", {31'b0, in_ready_o}, 32'd1);
        check_eq("arst out_valid", {31'b0, out_valid_o}, 32'd0);
        check_eq("arst out_data", out_data_o, 32'd0);
        check_eq("arst out_bytes", {29'b0, out_bytes_o}, 32'd0);
        check_eq("arst busy", {31'b0, busy_o}, 32'd0);
        check_eq("arst done", {31'b0, done_o}, 32'd0);
        @(negedge clk0);
        @(negedge clk0);
        check_eq("arst done_hold", {31'b0, done_o}, 32'd0);
        rst_i = 1'b0;

        words[0] = 16'hA1B2; words[1] = 16'hC3D4;
        exp_data[0] = 32'hD4C3B2A1; exp_bytes[0] = 3'd4;
        run_xfer("post_rst", 16'd4, 1'b0, 2, 1, 2, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
